// File: rtl/alu_sweep_checker_pkg.sv
// Shared types and the reference function for the 4-bit arithmetic unit sweep.
// The checker uses alu_expected() to build its expectations, and the unit's
// behavioural models call the same function.
package alu_sweep_checker_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    // Function-select encodings, indexed as {s0, s1}.
    typedef enum logic [1:0] {
        SEL_B     = 2'b00,
        SEL_NOT_B = 2'b01,
        SEL_ZERO  = 2'b10,
        SEL_ONES  = 2'b11
    } alu_sel_e;

    // Full-width result {cout, d} = A + Y + cin. Nothing is truncated before the compare.
    function automatic logic [ALU_WIDTH:0] alu_expected(
        input logic [ALU_WIDTH-1:0] a,
        input logic [ALU_WIDTH-1:0] b,
        input logic                 s0,
        input logic                 s1,
        input logic                 cin
    );
        logic [ALU_WIDTH-1:0] y;
        case ({s0, s1})
            SEL_B:     y = b;
            SEL_NOT_B: y = ~b;
            SEL_ZERO:  y = '0;
            default:   y = '1;
        endcase
        return {1'b0, a} + {1'b0, y} + {{ALU_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/alu_sweep_checker_expect_pipe.sv
// Expectation shift register. Each entry {valid, idx, expected} travels beside
// its vector, so the tail lines up with the unit's registered output.
module alu_sweep_checker_expect_pipe #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned IDX_W = 11,
    parameter int unsigned RES_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_valid_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic [RES_W-1:0] push_exp_i,
    output logic             tail_valid_o,
    output logic [IDX_W-1:0] tail_idx_o,
    output logic [RES_W-1:0] tail_exp_o
);

    localparam int unsigned ENTRY_W = 1 + IDX_W + RES_W;

    logic [ENTRY_W-1:0] stage_q [DEPTH];

    // Shift one stage per clock. A new sweep flushes every stage behind the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small array is reset on purpose. A stale valid bit left over
            // from an aborted sweep would otherwise be counted as a false mismatch.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage read its neighbour's
            // old value, so this is a shift and not a single-cycle pass-through.
            stage_q[0] <= {push_valid_i, push_idx_i, push_exp_i};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= clr_i ? '0 : stage_q[i-1];
            end
        end
    end

    assign {tail_valid_o, tail_idx_o, tail_exp_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/alu_sweep_checker.sv
// Bounded sweep driver and response checker for the registered arithmetic unit.
// It drives all {a, b, s0, s1, cin} vectors once, compares each registered
// {cout, d} against the pipelined expectation, and reports the verdict.
module alu_sweep_checker
    import alu_sweep_checker_pkg::*;
#(
    parameter int unsigned WIDTH   = ALU_WIDTH,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ERR_W   = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               s0_o,
    output logic               s1_o,
    output logic               cin_o,
    input  logic [WIDTH-1:0]   d_i,
    input  logic               cout_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH+2:0] first_fail,
    output logic               fail_seen
);

    localparam int unsigned IDX_W = 2 * WIDTH + 3;
    localparam int unsigned RES_W = WIDTH + 1;
    localparam int unsigned DEPTH = LATENCY + 1;
    localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] first_fail_q, first_fail_d;
    logic             fail_seen_q, fail_seen_d;

    logic             accept;
    logic             push_valid;
    logic [RES_W-1:0] push_exp;
    logic             tail_valid;
    logic [IDX_W-1:0] tail_idx;
    logic [RES_W-1:0] tail_exp;
    logic             mismatch;

    // Sweep sequencing. idx_d is always the vector that goes onto the pins next.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that skips
        // an assignment would otherwise infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        push_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_d    = ST_ISSUE;
                    idx_d      = '0;
                    push_valid = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (idx_q == IDX_MAX) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    push_valid = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == CNT_W'(LATENCY)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    assign done_d = (state_d == ST_DONE);

    assign push_exp = alu_expected(idx_d[IDX_W-1 -: WIDTH], idx_d[3 +: WIDTH],
                                   idx_d[2], idx_d[1], idx_d[0]);

    alu_sweep_checker_expect_pipe #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .RES_W (RES_W)
    ) u_expect_pipe (
        .clk          (CLK),
        .rst_n        (RST_N),
        .clr_i        (accept),
        .push_valid_i (push_valid),
        .push_idx_i   (idx_d),
        .push_exp_i   (push_exp),
        .tail_valid_o (tail_valid),
        .tail_idx_o   (tail_idx),
        .tail_exp_o   (tail_exp)
    );

    assign mismatch = tail_valid && ({cout_i, d_i} != tail_exp);

    // Error bookkeeping: a saturating count, a first-failure latch, and the verdict taken when DONE is entered.
    always_comb begin
        err_d        = err_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        pass_d       = pass_q;
        if (accept) begin
            err_d        = '0;
            first_fail_d = '0;
            fail_seen_d  = 1'b0;
            pass_d       = 1'b0;
        end else if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!fail_seen_q) begin
                first_fail_d = tail_idx;
                fail_seen_d  = 1'b1;
            end
        end
        if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
            pass_d = (err_d == '0);
        end
    end

    // State and output registers. Reset returns everything to zero at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    // The vector index is the stimulus register, so the pins hold in DRAIN and DONE.
    assign a_o        = idx_q[IDX_W-1 -: WIDTH];
    assign b_o        = idx_q[3 +: WIDTH];
    assign s0_o       = idx_q[2];
    assign s1_o       = idx_q[1];
    assign cin_o      = idx_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_fail_q;
    assign fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench for alu_sweep_checker. A two-stage behavioural model of the
// unit is attached, with optional faults: d[0] stuck at 0, or cout inverted.
module tb_alu_sweep_checker;
    import alu_sweep_checker_pkg::*;

    localparam int SWEEP_EDGES = 2051;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  a_o, b_o, d_i;
    logic        s0_o, s1_o, cin_o, cout_i;
    logic        busy, done, pass, fail_seen;
    logic [7:0]  err_count;
    logic [10:0] first_fail;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fault_mode = 0;
    int e_edge;

    logic [3:0] u_a = '0, u_b = '0;
    logic       u_s0 = 1'b0, u_s1 = 1'b0, u_cin = 1'b0;
    logic [4:0] u_res = '0;

    alu_sweep_checker dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .a_o        (a_o),
        .b_o        (b_o),
        .s0_o       (s0_o),
        .s1_o       (s1_o),
        .cin_o      (cin_o),
        .d_i        (d_i),
        .cout_i     (cout_i),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_seen  (fail_seen)
    );

    always #100 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Unit model: input register, then the registered result.
    always @(posedge CLK) begin
        u_a   <= a_o;
        u_b   <= b_o;
        u_s0  <= s0_o;
        u_s1  <= s1_o;
        u_cin <= cin_o;
        u_res <= alu_expected(u_a, u_b, u_s0, u_s1, u_cin);
    end

    assign d_i    = (fault_mode == 1) ? {u_res[3:1], 1'b0} : u_res[3:0];
    assign cout_i = (fault_mode == 2) ? ~u_res[4] : u_res[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_sweep(output int e);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        e = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int e, input string tag);
        int d_edge;
        d_edge = -1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                d_edge = cyc;
                break;
            end
        end
        check({tag, " done edge"}, d_edge - e, SWEEP_EDGES);
        check({tag, " busy at done"}, busy, 0);
    endtask

    initial begin
        // Reset values
        #250;
        check("rst pins", {a_o, b_o, s0_o, s1_o, cin_o}, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst err_count", err_count, 0);
        check("rst first_fail", first_fail, 0);
        check("rst fail_seen", fail_seen, 0);

        // Reference function, hand-computed
        check("fn 1010+~0101+1", alu_expected(4'b1010, 4'b0101, 1'b0, 1'b1, 1'b1), 5'b1_0101);
        check("fn 1111+0000+1", alu_expected(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1), 5'b1_0000);
        check("fn 0011+0+0", alu_expected(4'b0011, 4'b1001, 1'b1, 1'b0, 1'b0), 5'b0_0011);
        check("fn 0111+1111+1", alu_expected(4'b0111, 4'b0010, 1'b1, 1'b1, 1'b1), 5'b1_0111);

        @(negedge CLK);
        RST_N = 1'b1;

        // Fault-free sweep, with a spot vector
        start_sweep(e_edge);
        check("accept busy", busy, 1);
        check("accept done", done, 0);
        check("accept pins", {a_o, b_o, s0_o, s1_o, cin_o}, 0);
        repeat (1323) @(posedge CLK);
        #1;
        check("spot a", a_o, 4'b1010);
        check("spot b", b_o, 4'b0101);
        check("spot s0s1", {s0_o, s1_o}, 2'b01);
        check("spot cin", cin_o, 1);
        repeat (2) @(posedge CLK);
        #1;
        check("spot unit result", {cout_i, d_i}, 5'b1_0101);
        @(posedge CLK);
        #1;
        check("spot err_count", err_count, 0);
        wait_done(e_edge, "clean");
        check("clean pass", pass, 1);
        check("clean err_count", err_count, 0);
        check("clean fail_seen", fail_seen, 0);
        check("clean pins hold", {a_o, b_o, s0_o, s1_o, cin_o}, 11'h7FF);

        // d[0] stuck at 0
        fault_mode = 1;
        start_sweep(e_edge);
        wait_done(e_edge, "stuck d0");
        check("stuck d0 first_fail", first_fail, 1);
        check("stuck d0 fail_seen", fail_seen, 1);
        check("stuck d0 err_count", err_count, 255);
        check("stuck d0 pass", pass, 0);

        // Inverted cout
        fault_mode = 2;
        start_sweep(e_edge);
        wait_done(e_edge, "inv cout");
        check("inv cout first_fail", first_fail, 0);
        check("inv cout err_count", err_count, 255);
        check("inv cout fail_seen", fail_seen, 1);
        check("inv cout pass", pass, 0);

        // Restart from DONE clears the verdict; a start while busy is ignored
        fault_mode = 0;
        start_sweep(e_edge);
        check("rerun done", done, 0);
        check("rerun err_count", err_count, 0);
        check("rerun fail_seen", fail_seen, 0);
        check("rerun first_fail", first_fail, 0);
        check("rerun pass", pass, 0);
        repeat (99) @(posedge CLK);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("busy start pins", {a_o, b_o, s0_o, s1_o, cin_o}, 100);
        wait_done(e_edge, "busy start");
        check("busy start pass", pass, 1);
        check("busy start err_count", err_count, 0);

        // Reset in the middle of a sweep
        fault_mode = 1;
        start_sweep(e_edge);
        repeat (700) @(posedge CLK);
        #1;
        check("mid pins", {a_o, b_o, s0_o, s1_o, cin_o}, 700);
        check("mid fail_seen", fail_seen, 1);
        #50;
        RST_N = 1'b0;
        #1;
        check("mid rst pins", {a_o, b_o, s0_o, s1_o, cin_o}, 0);
        check("mid rst flags", {busy, done, pass, fail_seen}, 0);
        check("mid rst err_count", err_count, 0);
        check("mid rst first_fail", first_fail, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        fault_mode = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("post rst idle", {busy, done}, 0);
        start_sweep(e_edge);
        check("restart pins", {a_o, b_o, s0_o, s1_o, cin_o}, 0);
        wait_done(e_edge, "restart");
        check("restart pass", pass, 1);
        check("restart err_count", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
